condicionador_botoes: RTL
=========================

CONDICIONADOR_BOTOES -- requirements
Module: condicionador_botoes

Interface
REQ-001 The module SHALL have parameter DEBOUNCE_CICLOS, default 5, meaning consecutive stable synchronized samples needed to accept a press or release (legal range 2..255).
REQ-002 The module SHALL have port clock, input, 1 bit: system clock (1 kHz nominal).
REQ-003 The module SHALL have port reset, input, 1 bit: one clock; reset is synchronous and active-high.
REQ-004 The module SHALL have port botoes, input, 4 bits: raw asynchronous push buttons, active-high.
REQ-005 The module SHALL have port habilita, input, 1 bit: game controller accepts plays when high.
REQ-006 The module SHALL have port jogada, output, 4 bits: last accepted one-hot play, registered.
REQ-007 The module SHALL have port jogada_feita, output, 1 bit: one-cycle pulse per accepted play, feeding the game core's play-strobe.
REQ-008 The module SHALL have port erro_multiplo, output, 1 bit: one-cycle pulse when a stable multi-button press is rejected.
REQ-009 The module SHALL have port db_estado, output, 3 bits: current FSM state code.

Function
REQ-010 botoes SHALL pass through a 2-flop synchronizer per bit; the second-stage value is "sinc".
REQ-011 FSM states, codes: ESPERA=0, FILTRA=1, EMITE=2, ERRO=3, SEGURA=4; unused codes SHALL go to ESPERA on the next edge.
REQ-012 ESPERA: habilita=1 and sinc!=0 -> FILTRA, amostra<=sinc, cnt<=1; otherwise stay.
REQ-013 FILTRA: habilita=0 or sinc=0 -> ESPERA; sinc!=amostra (nonzero) -> stay, amostra<=sinc, cnt<=1; sinc=amostra and cnt=DEBOUNCE_CICLOS-1 -> EMITE if amostra is one-hot, else ERRO; otherwise cnt<=cnt+1.
REQ-014 On entry to EMITE, jogada SHALL load amostra on the same edge.
REQ-015 EMITE SHALL last exactly one cycle with jogada_feita=1, then -> SEGURA.
REQ-016 ERRO SHALL last exactly one cycle with erro_multiplo=1, then -> SEGURA; jogada unchanged.
REQ-017 SEGURA: sinc!=0 -> cnt<=0; sinc=0 -> cnt<=cnt+1; when sinc=0 and cnt=DEBOUNCE_CICLOS-1 -> ESPERA; habilita SHALL be ignored.
REQ-018 Latency: with botoes held constant, jogada_feita SHALL be high during the cycle after the (DEBOUNCE_CICLOS+2)th rising edge counted from the first edge that samples the press (edge 7 for default).
REQ-019 A press held any length SHALL produce at most one jogada_feita; a new play requires a debounced release.
REQ-020 Glitches shorter than DEBOUNCE_CICLOS samples SHALL produce no pulse.
REQ-021 jogada_feita and erro_multiplo SHALL never be high in the same cycle; both Moore outputs.
REQ-022 jogada SHALL hold its value until the next EMITE entry or reset.
REQ-023 cnt width SHALL be $clog2(DEBOUNCE_CICLOS+1); it SHALL never wrap.

Reset
REQ-024 reset=1 at a rising edge SHALL set state=ESPERA, cnt=0, amostra=0, jogada=0000, synchronizer flops=0, jogada_feita=0, erro_multiplo=0, db_estado=000.
REQ-025 reset SHALL override all transitions, including mid-FILTRA and during EMITE; no pulse is emitted in the cycle after reset.

Structure
REQ-026 State codes and the DEBOUNCE_CICLOS default SHALL live in the shared neurosync package.
REQ-027 The synchronizer SHALL be a separate sub-module, sincronizador_2ff, parameterized by width (4 here).
REQ-028 No other sub-modules; FSM, counter and one-hot check stay in condicionador_botoes.

Verification
REQ-029 Reset, habilita=1, botoes=0001 for 10 cycles -> single jogada_feita pulse on cycle 7 after press, jogada=0001, db_estado back to 0 after release debounce.
REQ-030 botoes=0100 for 3 cycles, then 0 -> no jogada_feita, no erro_multiplo, jogada unchanged.
REQ-031 botoes=0110 for 10 cycles -> single erro_multiplo pulse, no jogada_feita, jogada keeps prior value.
REQ-032 botoes=1000 held 50 cycles, released, held again 10 cycles -> exactly two jogada_feita pulses, jogada=1000.
REQ-033 habilita=0, botoes=0010 for 10 cycles -> no pulse, db_estado stays 0.
REQ-034 reset asserted 1 cycle while in FILTRA with botoes=0001 held -> no pulse that cycle; new pulse 7 cycles after reset release, jogada=0001.

Source files
------------

// File: rtl/neurosync_pkg.sv
// Shared definitions for the neurosync game blocks: button conditioner state
// codes, default debounce length and a one-hot helper.
package neurosync_pkg;

    localparam int DEBOUNCE_CICLOS_PADRAO = 5;
    localparam int NUM_BOTOES             = 4;

    typedef enum logic [2:0] {
        ESPERA = 3'd0,
        FILTRA = 3'd1,
        EMITE  = 3'd2,
        ERRO   = 3'd3,
        SEGURA = 3'd4
    } estado_t;

    // True when exactly one bit is set.
    function automatic logic eh_one_hot(input logic [NUM_BOTOES-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchronizer, one chain per bit, for asynchronous inputs.
module sincronizador_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/condicionador_botoes.sv
// Push-button conditioner: synchronizes, debounces and validates one-hot plays,
// emitting a single strobe per press and requiring a debounced release between plays.
module condicionador_botoes
    import neurosync_pkg::*;
#(
    parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_BOTOES-1:0] botoes,
    input  logic                  habilita,
    output logic [NUM_BOTOES-1:0] jogada,
    output logic                  jogada_feita,
    output logic                  erro_multiplo,
    output logic [2:0]            db_estado
);

    localparam int              CW      = $clog2(DEBOUNCE_CICLOS + 1);
    localparam logic [CW-1:0]   CNT_ULT = CW'(DEBOUNCE_CICLOS - 1);
    localparam logic [CW-1:0]   CNT_UM  = CW'(1);

    logic [NUM_BOTOES-1:0] sinc;
    estado_t               estado, estado_d;
    logic [CW-1:0]         cnt, cnt_d;
    logic [NUM_BOTOES-1:0] amostra, amostra_d;
    logic [NUM_BOTOES-1:0] jogada_d;

    sincronizador_2ff #(.WIDTH(NUM_BOTOES)) u_sinc (
        .clock (clock),
        .reset (reset),
        .d     (botoes),
        .q     (sinc)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            estado  <= ESPERA;
            cnt     <= '0;
            amostra <= '0;
            jogada  <= '0;
        end else begin
            estado  <= estado_d;
            cnt     <= cnt_d;
            amostra <= amostra_d;
            jogada  <= jogada_d;
        end
    end

    always_comb begin
        estado_d  = estado;
        cnt_d     = cnt;
        amostra_d = amostra;
        jogada_d  = jogada;
        unique case (estado)
            ESPERA: begin
                if (habilita && sinc != '0) begin
                    estado_d  = FILTRA;
                    amostra_d = sinc;
                    cnt_d     = CNT_UM;
                end
            end
            FILTRA: begin
                if (!habilita || sinc == '0) begin
                    estado_d = ESPERA;
                    cnt_d    = '0;
                end else if (sinc != amostra) begin
                    // a different combination restarts the stability window
                    amostra_d = sinc;
                    cnt_d     = CNT_UM;
                end else if (cnt == CNT_ULT) begin
                    cnt_d = '0;
                    if (eh_one_hot(amostra)) begin
                        estado_d = EMITE;
                        jogada_d = amostra;
                    end else begin
                        estado_d = ERRO;
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            EMITE, ERRO: begin
                estado_d = SEGURA;
                cnt_d    = '0;
            end
            SEGURA: begin
                // counts consecutive released samples; any press restarts it
                if (sinc != '0) begin
                    cnt_d = '0;
                end else if (cnt == CNT_ULT) begin
                    estado_d = ESPERA;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: begin
                estado_d = ESPERA;
                cnt_d    = '0;
            end
        endcase
    end

    assign jogada_feita  = (estado == EMITE);
    assign erro_multiplo = (estado == ERRO);
    assign db_estado     = estado;

endmodule
